mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between the MIPS core's instruction

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports of the core.
// It registers the winning request, drives the memory handshake, returns a one-cycle ack and aborts on timeout.
//
// state  | meaning
// S_IDLE | waiting for a request; arbitration and grant happen here
// S_BUSY | m_req held high; waiting for m_ack or the timeout
// S_RESP | owner's ack (and bus_err on timeout) pulse; no memory request
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              bus_err,
  output logic              busy
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TMO_W    = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = data port owns the transaction
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                m_req_q, m_req_d;
  logic                busy_q, busy_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                bus_err_q, bus_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    m_req_d    = m_req_q;
    busy_d     = busy_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    bus_err_d  = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_data = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // Data has priority until the fetch port has watched STARVE_LIMIT data grants go by.
          grant_data = d_req && !(i_req && (starve_q == STARVE_MAX));
          owner_d    = grant_data;
          we_d       = grant_data ? d_we : 1'b0;
          addr_d     = grant_data ? d_addr : i_addr;
          wdata_d    = grant_data ? d_wdata : '0;
          if (grant_data && i_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
          end else begin
            starve_d = '0;
          end
          tmo_d   = '0;
          m_req_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (m_ack) begin
          if (owner_q) d_rdata_d = m_rdata;
          else         i_rdata_d = m_rdata;
          d_ack_d = owner_q;
          i_ack_d = !owner_q;
          m_req_d = 1'b0;
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          if (owner_q) d_rdata_d = '0;
          else         i_rdata_d = '0;
          d_ack_d   = owner_q;
          i_ack_d   = !owner_q;
          bus_err_d = 1'b1;
          m_req_d   = 1'b0;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        tmo_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        m_req_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      tmo_q     <= '0;
      m_req_q   <= 1'b0;
      busy_q    <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      m_req_q   <= m_req_d;
      busy_q    <= busy_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;
  assign busy    = busy_q;

endmodule
